// File: rtl/mem_arbiter_pkg.sv
// lisp_defs: shared definitions for the cons-cell memory subsystem.
//   arb_state_t : mem_arbiter FSM states (IDLE, ISSUE, WAIT)
//   REQ_CORE    : requester id of the evaluator core (requester 0)
//   REQ_GC      : requester id of the GC mark engine (requester 1)
//   cell_t      : one cons cell as returned by memory (header, car, cdr)
package lisp_defs;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT
  } arb_state_t;

  localparam logic REQ_CORE = 1'b0;
  localparam logic REQ_GC   = 1'b1;

  typedef struct packed {
    logic [15:0] header;
    logic [15:0] car;
    logic [15:0] cdr;
  } cell_t;

endpackage

// File: rtl/mem_arbiter_watchdog.sv
// arb_watchdog: read timeout counter for mem_arbiter (used only when
// MEM_ARB_TIMEOUT_EN is defined).
//   clk, rst : clock, synchronous active-high reset
//   start    : clears the count (asserted the cycle before WAIT is entered)
//   running  : count advances while high (arbiter is in WAIT)
//   expired  : high in the TIMEOUT_CYCLES-th consecutive running cycle
module arb_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic running,
  output logic expired
);

  localparam int unsigned CW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);

  logic [CW-1:0] cnt_q;

  // Count is 0 in the first WAIT cycle, so expiry fires on count TIMEOUT_CYCLES-1.
  assign expired = running && (cnt_q == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst || start) begin
      cnt_q <= '0;
    end else if (running && !expired) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter sharing the cons-cell memory read port
// between the evaluator core (r0) and the GC mark engine (r1). One read is
// outstanding at a time; requests and responses are single-cycle pulses.
//   clk, rst                 : clock, synchronous active-high reset
//   rN_req / rN_addr         : request pulse and cell address
//   rN_busy                  : read pending or in service for requester N
//   rN_done / rN_err         : response pulse, timeout-abort flag
//   rN_header/car/cdr        : held response data for requester N
//   mem_read_enable/mem_addr : memory read command (registered)
//   mem_header/car/cdr/done  : memory response
// Optional: define MEM_ARB_TIMEOUT_EN to abort reads that wait longer than
// TIMEOUT_CYCLES cycles for mem_done.
module mem_arbiter
  import lisp_defs::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        r0_req,
  input  logic [15:0] r0_addr,
  output logic        r0_busy,
  output logic        r0_done,
  output logic        r0_err,
  output logic [15:0] r0_header,
  output logic [15:0] r0_car,
  output logic [15:0] r0_cdr,
  input  logic        r1_req,
  input  logic [15:0] r1_addr,
  output logic        r1_busy,
  output logic        r1_done,
  output logic        r1_err,
  output logic [15:0] r1_header,
  output logic [15:0] r1_car,
  output logic [15:0] r1_cdr,
  output logic        mem_read_enable,
  output logic [15:0] mem_addr,
  input  logic [15:0] mem_header,
  input  logic [15:0] mem_car,
  input  logic [15:0] mem_cdr,
  input  logic        mem_done
);

  arb_state_t  state_q, state_d;
  logic        pend0_q, pend0_d, pend1_q, pend1_d;
  logic [15:0] addr0_q, addr0_d, addr1_q, addr1_d;
  logic        grant_q, grant_d;
  logic        last_grant_q, last_grant_d;
  logic [15:0] mem_addr_q, mem_addr_d;
  logic        mre_q, mre_d;
  logic        done0_q, done0_d, done1_q, done1_d;
  logic        err0_q, err0_d, err1_q, err1_d;
  cell_t       resp0_q, resp0_d, resp1_q, resp1_d;

  logic        acc0, acc1, cand0, cand1, pick;
  logic        timeout_hit;

`ifdef MEM_ARB_TIMEOUT_EN
  arb_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk    (clk),
    .rst    (rst),
    .start  (state_q == ISSUE),
    .running(state_q == WAIT),
    .expired(timeout_hit)
  );
`else
  assign timeout_hit = 1'b0;
`endif

  assign r0_busy = pend0_q | ((grant_q == REQ_CORE) && (state_q != IDLE));
  assign r1_busy = pend1_q | ((grant_q == REQ_GC) && (state_q != IDLE));

  // A request seen while busy is dropped and leaves the latched address alone.
  assign acc0 = r0_req & ~r0_busy;
  assign acc1 = r1_req & ~r1_busy;

  // Bypass: a fresh request competes in the same IDLE cycle it arrives.
  assign cand0 = pend0_q | r0_req;
  assign cand1 = pend1_q | r1_req;

  always_comb begin
    state_d      = state_q;
    pend0_d      = pend0_q | acc0;
    pend1_d      = pend1_q | acc1;
    addr0_d      = acc0 ? r0_addr : addr0_q;
    addr1_d      = acc1 ? r1_addr : addr1_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    mem_addr_d   = mem_addr_q;
    mre_d        = 1'b0;
    done0_d      = 1'b0;
    done1_d      = 1'b0;
    err0_d       = err0_q;
    err1_d       = err1_q;
    resp0_d      = resp0_q;
    resp1_d      = resp1_q;
    pick         = REQ_CORE;

    unique case (state_q)
      IDLE: begin
        if (cand0 | cand1) begin
          pick         = (cand0 & cand1) ? ~last_grant_q : cand1;
          grant_d      = pick;
          last_grant_d = pick;
          mre_d        = 1'b1;
          state_d      = ISSUE;
          if (pick == REQ_GC) begin
            mem_addr_d = pend1_q ? addr1_q : r1_addr;
          end else begin
            mem_addr_d = pend0_q ? addr0_q : r0_addr;
          end
        end
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        if (mem_done || timeout_hit) begin
          state_d = IDLE;
          if (grant_q == REQ_GC) begin
            resp1_d = mem_done ? cell_t'{header: mem_header, car: mem_car, cdr: mem_cdr} : '0;
            err1_d  = ~mem_done;
            done1_d = 1'b1;
            pend1_d = 1'b0;
          end else begin
            resp0_d = mem_done ? cell_t'{header: mem_header, car: mem_car, cdr: mem_cdr} : '0;
            err0_d  = ~mem_done;
            done0_d = 1'b1;
            pend0_d = 1'b0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      pend0_q      <= 1'b0;
      pend1_q      <= 1'b0;
      addr0_q      <= '0;
      addr1_q      <= '0;
      grant_q      <= REQ_CORE;
      last_grant_q <= REQ_GC;
      mem_addr_q   <= '0;
      mre_q        <= 1'b0;
      done0_q      <= 1'b0;
      done1_q      <= 1'b0;
      err0_q       <= 1'b0;
      err1_q       <= 1'b0;
      resp0_q      <= '0;
      resp1_q      <= '0;
    end else begin
      state_q      <= state_d;
      pend0_q      <= pend0_d;
      pend1_q      <= pend1_d;
      addr0_q      <= addr0_d;
      addr1_q      <= addr1_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      mem_addr_q   <= mem_addr_d;
      mre_q        <= mre_d;
      done0_q      <= done0_d;
      done1_q      <= done1_d;
      err0_q       <= err0_d;
      err1_q       <= err1_d;
      resp0_q      <= resp0_d;
      resp1_q      <= resp1_d;
    end
  end

  assign mem_read_enable = mre_q;
  assign mem_addr        = mem_addr_q;
  assign r0_done         = done0_q;
  assign r1_done         = done1_q;
  assign r0_err          = err0_q;
  assign r1_err          = err1_q;
  assign r0_header       = resp0_q.header;
  assign r0_car          = resp0_q.car;
  assign r0_cdr          = resp0_q.cdr;
  assign r1_header       = resp1_q.header;
  assign r1_car          = resp1_q.car;
  assign r1_cdr          = resp1_q.cdr;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: scoreboard bench for mem_arbiter. Stimulus pushes expected
// memory reads and responses into queues; a monitor pops and compares on every
// mem_read_enable / rN_done. Memory model answers with fixed 2-cycle latency.
module tb_mem_arbiter;
  import lisp_defs::*;

  localparam int MEM_LAT = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        r0_req = 1'b0, r1_req = 1'b0;
  logic [15:0] r0_addr = '0, r1_addr = '0;
  logic        r0_busy, r0_done, r0_err, r1_busy, r1_done, r1_err;
  logic [15:0] r0_header, r0_car, r0_cdr, r1_header, r1_car, r1_cdr;
  logic        mem_read_enable;
  logic [15:0] mem_addr;
  logic [15:0] mem_header = '0, mem_car = '0, mem_cdr = '0;
  logic        mem_done = 1'b0;
  logic        mem_silent = 1'b0;

  mem_arbiter #(.TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst(rst),
    .r0_req(r0_req), .r0_addr(r0_addr), .r0_busy(r0_busy), .r0_done(r0_done),
    .r0_err(r0_err), .r0_header(r0_header), .r0_car(r0_car), .r0_cdr(r0_cdr),
    .r1_req(r1_req), .r1_addr(r1_addr), .r1_busy(r1_busy), .r1_done(r1_done),
    .r1_err(r1_err), .r1_header(r1_header), .r1_car(r1_car), .r1_cdr(r1_cdr),
    .mem_read_enable(mem_read_enable), .mem_addr(mem_addr),
    .mem_header(mem_header), .mem_car(mem_car), .mem_cdr(mem_cdr),
    .mem_done(mem_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a;
    int          due;
  } rd_t;

  typedef struct {
    logic [47:0] data;
    logic        err;
    int          due;
  } resp_t;

  rd_t   exp_rd[$];
  resp_t exp0[$];
  resp_t exp1[$];

  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Memory contents, one entry per address used by the bench.
  function automatic logic [47:0] mem_word(input logic [15:0] a);
    case (a)
      16'h0010: return {16'h0001, 16'h002A, 16'h0000};
      16'h0020: return {16'h8002, 16'h0055, 16'h0010};
      16'h0030: return {16'h0003, 16'h0033, 16'h0031};
      default:  return {16'hDEAD, 16'hDEAD, 16'hDEAD};
    endcase
  endfunction

  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
  end

  // Memory model: mem_done MEM_LAT cycles after the read-enable cycle.
  initial begin
    int          mcnt;
    logic [15:0] maddr;
    mcnt  = 0;
    maddr = '0;
    forever begin
      @(negedge clk);
      mem_done = 1'b0;
      if (mcnt > 0) begin
        mcnt--;
        if (mcnt == 0 && !mem_silent) begin
          {mem_header, mem_car, mem_cdr} = mem_word(maddr);
          mem_done = 1'b1;
        end
      end
      if (mem_read_enable) begin
        mcnt  = MEM_LAT;
        maddr = mem_addr;
      end
    end
  end

  // Monitor / scoreboard.
  initial forever begin
    rd_t   r;
    resp_t e;
    @(negedge clk);
    if (!rst && mem_read_enable) begin
      if (exp_rd.size() == 0) check("unexpected mem read", 64'(mem_addr), 64'hFFFF_FFFF);
      else begin
        r = exp_rd.pop_front();
        check("mem_addr", 64'(mem_addr), 64'(r.a));
        if (r.due >= 0) check("mem read cycle", 64'(cyc), 64'(r.due));
      end
    end
    if (r0_done) begin
      if (exp0.size() == 0) check("unexpected r0_done", 64'(r0_done), 64'd0);
      else begin
        e = exp0.pop_front();
        check("r0 data", 64'({r0_header, r0_car, r0_cdr}), 64'(e.data));
        check("r0_err", 64'(r0_err), 64'(e.err));
        if (e.due >= 0) check("r0_done cycle", 64'(cyc), 64'(e.due));
      end
    end
    if (r1_done) begin
      if (exp1.size() == 0) check("unexpected r1_done", 64'(r1_done), 64'd0);
      else begin
        e = exp1.pop_front();
        check("r1 data", 64'({r1_header, r1_car, r1_cdr}), 64'(e.data));
        check("r1_err", 64'(r1_err), 64'(e.err));
        if (e.due >= 0) check("r1_done cycle", 64'(cyc), 64'(e.due));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while ((exp_rd.size() != 0 || exp0.size() != 0 || exp1.size() != 0 || r0_busy || r1_busy)
           && n < 300) begin
      tick();
      n++;
    end
    if (n >= 300) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s drain: still busy after %0d cycles, expected idle", tag, n);
    end
    repeat (3) tick();
  endtask

  task automatic check_zero(input string tag);
    check({tag, " flags"}, 64'({r0_busy, r0_done, r0_err, r1_busy, r1_done, r1_err, mem_read_enable}), 64'd0);
    check({tag, " r0 data"}, 64'({r0_header, r0_car, r0_cdr}), 64'd0);
    check({tag, " r1 data"}, 64'({r1_header, r1_car, r1_cdr}), 64'd0);
    check({tag, " mem_addr"}, 64'(mem_addr), 64'd0);
  endtask

  localparam logic [47:0] D10 = {16'h0001, 16'h002A, 16'h0000};
  localparam logic [47:0] D20 = {16'h8002, 16'h0055, 16'h0010};
  localparam logic [47:0] D30 = {16'h0003, 16'h0033, 16'h0031};

  initial begin
    int c0;
    int issued;
    int n;

    rst = 1'b1;
    repeat (3) tick();
    check_zero("reset");
    rst = 1'b0;
    tick();

    // Single read by r0.
    c0 = cyc;
    exp_rd.push_back('{16'h0010, c0 + 1});
    exp0.push_back('{D10, 1'b0, c0 + 4});
    r0_req = 1'b1; r0_addr = 16'h0010;
    tick();
    r0_req = 1'b0;
    check("r0_busy in service", 64'(r0_busy), 64'd1);
    drain("single");
    check("r0_car held", 64'(r0_car), 64'h002A);

    // Tie right after reset: r0 first.
    rst = 1'b1; tick(); rst = 1'b0; tick();
    exp_rd.push_back('{16'h0010, -1});
    exp_rd.push_back('{16'h0020, -1});
    exp0.push_back('{D10, 1'b0, -1});
    exp1.push_back('{D20, 1'b0, -1});
    r0_req = 1'b1; r0_addr = 16'h0010;
    r1_req = 1'b1; r1_addr = 16'h0020;
    tick();
    r0_req = 1'b0; r1_req = 1'b0;
    drain("tie");

    // Fairness: both re-request on their own done, 8 grants total.
    for (int unsigned i = 0; i < 8; i++) begin
      exp_rd.push_back('{(i % 2 == 0) ? 16'h0010 : 16'h0020, -1});
      if (i % 2 == 0) exp0.push_back('{D10, 1'b0, -1});
      else            exp1.push_back('{D20, 1'b0, -1});
    end
    issued = 2;
    r0_req = 1'b1; r0_addr = 16'h0010;
    r1_req = 1'b1; r1_addr = 16'h0020;
    tick();
    r0_req = 1'b0; r1_req = 1'b0;
    n = 0;
    while ((exp0.size() != 0 || exp1.size() != 0) && n < 400) begin
      r0_req = 1'b0; r1_req = 1'b0;
      if (r0_done && issued < 8) begin r0_req = 1'b1; issued++; end
      if (r1_done && issued < 8) begin r1_req = 1'b1; issued++; end
      tick();
      n++;
    end
    r0_req = 1'b0; r1_req = 1'b0;
    drain("fairness");

    // Duplicate request while busy is ignored.
    c0 = cyc;
    exp_rd.push_back('{16'h0030, c0 + 1});
    exp1.push_back('{D30, 1'b0, c0 + 4});
    r1_req = 1'b1; r1_addr = 16'h0030;
    tick();
    check("r1_busy before dup", 64'(r1_busy), 64'd1);
    r1_req = 1'b1; r1_addr = 16'h0040;
    tick();
    r1_req = 1'b0;
    drain("duplicate");
    check("r0 data untouched", 64'({r0_header, r0_car, r0_cdr}), 64'(D10));

    // Reset one cycle after mem_read_enable; late mem_done must be ignored.
    c0 = cyc;
    exp_rd.push_back('{16'h0010, c0 + 1});
    r0_req = 1'b1; r0_addr = 16'h0010;
    tick();
    r0_req = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    repeat (4) tick();
    check_zero("reset mid-WAIT");
    check("state after reset", 64'(dut.state_q), 64'(IDLE));

`ifdef MEM_ARB_TIMEOUT_EN
    // Timeout: memory never answers.
    mem_silent = 1'b1;
    c0 = cyc;
    exp_rd.push_back('{16'h0010, c0 + 1});
    exp0.push_back('{48'd0, 1'b1, c0 + 10});
    r0_req = 1'b1; r0_addr = 16'h0010;
    tick();
    r0_req = 1'b0;
    drain("timeout");
    mem_silent = 1'b0;
    repeat (4) tick();
    exp_rd.push_back('{16'h0020, -1});
    exp0.push_back('{D20, 1'b0, -1});
    r0_req = 1'b1; r0_addr = 16'h0020;
    tick();
    r0_req = 1'b0;
    drain("after timeout");
`endif

    check("leftover expectations", 64'(exp_rd.size() + exp0.size() + exp1.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
